bus_arbiter: RTL and testbench

- Two-core arbiter for the shared snoop bus and L2 port between cpu1, cpu2 and bus_controller.
- Takes req_core1/req_core2 and issues registered one-hot grants, using round-robin fairness.
- Bounds each tenure with a hold limit. A forced hand-off happens only at transaction boundaries, which are signalled by l2_busy.
- Inserts one dead turnaround cycle between owners so bus_controller muxes never see two drivers.

---
 rtl/bus_arbiter_if.sv | 39 +++
 rtl/bus_arbiter.sv | 123 ++++++++++++
 tb/tb_bus_arbiter.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/bus_arbiter_if.sv
// Signal bundle between the two-core bus arbiter and its requesters.
// Stats counters exist only when BUS_ARB_STATS_EN is defined.
interface bus_arbiter_if;
  logic       req_core1;
  logic       req_core2;
  logic       l2_busy;
  logic       grant_core1;
  logic       grant_core2;
  logic [1:0] owner_id;
  logic       bus_idle;
  logic       preempt;
`ifdef BUS_ARB_STATS_EN
  logic [31:0] grant_cnt1;
  logic [31:0] grant_cnt2;
  logic [15:0] preempt_cnt;

  modport master (
    input  req_core1, req_core2, l2_busy,
    output grant_core1, grant_core2, owner_id, bus_idle, preempt,
    output grant_cnt1, grant_cnt2, preempt_cnt
  );

  modport slave (
    output req_core1, req_core2, l2_busy,
    input  grant_core1, grant_core2, owner_id, bus_idle, preempt,
    input  grant_cnt1, grant_cnt2, preempt_cnt
  );
`else
  modport master (
    input  req_core1, req_core2, l2_busy,
    output grant_core1, grant_core2, owner_id, bus_idle, preempt
  );

  modport slave (
    output req_core1, req_core2, l2_busy,
    input  grant_core1, grant_core2, owner_id, bus_idle, preempt
  );
`endif
endinterface

// File: rtl/bus_arbiter.sv
// Round-robin two-core snoop/L2 bus arbiter with hold-limit preemption and a dead turnaround cycle.
// Optional grant/preempt statistics counters are enabled by defining BUS_ARB_STATS_EN.
module bus_arbiter #(
  parameter int unsigned MAX_HOLD = 16,
  parameter int unsigned CNT_W    = 5
) (
  input  logic          i_clk,
  input  logic          i_reset,
  bus_arbiter_if.master bus
);

  typedef enum logic [1:0] {StIdle, StOwn1, StOwn2, StTurn} state_e;

  localparam logic [CNT_W-1:0] MaxHold = CNT_W'(MAX_HOLD);
  localparam logic [CNT_W-1:0] CntOne  = CNT_W'(1);

  state_e           r_state, w_state_d;
  logic [CNT_W-1:0] r_cnt, w_cnt_d;
  logic             r_rr, w_rr_d;
  logic             r_preempt, w_preempt_d;

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_state   <= StIdle;
      r_cnt     <= '0;
      r_rr      <= 1'b0;
      r_preempt <= 1'b0;
    end else begin
      r_state   <= w_state_d;
      r_cnt     <= w_cnt_d;
      r_rr      <= w_rr_d;
      r_preempt <= w_preempt_d;
    end
  end

  always_comb begin
    w_state_d   = r_state;
    w_cnt_d     = r_cnt;
    w_rr_d      = r_rr;
    w_preempt_d = 1'b0;
    unique case (r_state)
      StIdle: begin
        // r_rr = 0 favours core1 on a tie, r_rr = 1 favours core2
        if (!bus.l2_busy) begin
          if (bus.req_core1 && (!bus.req_core2 || !r_rr)) begin
            w_state_d = StOwn1;
            w_cnt_d   = CntOne;
            w_rr_d    = 1'b1;
          end else if (bus.req_core2) begin
            w_state_d = StOwn2;
            w_cnt_d   = CntOne;
            w_rr_d    = 1'b0;
          end
        end
      end
      StOwn1: begin
        if (r_cnt != MaxHold) w_cnt_d = r_cnt + CntOne;
        if (!bus.l2_busy) begin
          if (!bus.req_core1) begin
            w_state_d = StTurn;
          end else if ((r_cnt == MaxHold) && bus.req_core2) begin
            w_state_d   = StTurn;
            w_preempt_d = 1'b1;
          end
        end
      end
      StOwn2: begin
        if (r_cnt != MaxHold) w_cnt_d = r_cnt + CntOne;
        if (!bus.l2_busy) begin
          if (!bus.req_core2) begin
            w_state_d = StTurn;
          end else if ((r_cnt == MaxHold) && bus.req_core1) begin
            w_state_d   = StTurn;
            w_preempt_d = 1'b1;
          end
        end
      end
      StTurn: begin
        w_state_d = StIdle;
        w_cnt_d   = '0;
      end
      default: begin
        w_state_d = StIdle;
        w_cnt_d   = '0;
      end
    endcase
  end

  // All outputs are pure decodes of flops, so reset clears them without waiting for a clock.
  assign bus.grant_core1 = (r_state == StOwn1);
  assign bus.grant_core2 = (r_state == StOwn2);
  assign bus.owner_id    = {bus.grant_core2, bus.grant_core1};
  assign bus.bus_idle    = (r_state == StIdle);
  assign bus.preempt     = r_preempt;

`ifdef BUS_ARB_STATS_EN
  logic [31:0] r_grant_cnt1;
  logic [31:0] r_grant_cnt2;
  logic [15:0] r_preempt_cnt;
  logic        w_own1_entry;
  logic        w_own2_entry;

  assign w_own1_entry = (r_state == StIdle) && (w_state_d == StOwn1);
  assign w_own2_entry = (r_state == StIdle) && (w_state_d == StOwn2);

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_grant_cnt1  <= '0;
      r_grant_cnt2  <= '0;
      r_preempt_cnt <= '0;
    end else begin
      if (w_own1_entry) r_grant_cnt1 <= r_grant_cnt1 + 32'd1;
      if (w_own2_entry) r_grant_cnt2 <= r_grant_cnt2 + 32'd1;
      if (w_preempt_d)  r_preempt_cnt <= r_preempt_cnt + 16'd1;
    end
  end

  assign bus.grant_cnt1  = r_grant_cnt1;
  assign bus.grant_cnt2  = r_grant_cnt2;
  assign bus.preempt_cnt = r_preempt_cnt;
`endif

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed self-checking bench for bus_arbiter; inputs change and outputs are checked at negedge.
module tb_bus_arbiter;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_err;
  logic mon_en;

  bus_arbiter_if u_bus ();

  bus_arbiter #(
    .MAX_HOLD (16),
    .CNT_W    (5)
  ) u_dut (
    .i_clk   (clk),
    .i_reset (rst_n),
    .bus     (u_bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n             = 1'b0;
    u_bus.req_core1   = 1'b0;
    u_bus.req_core2   = 1'b0;
    u_bus.l2_busy     = 1'b0;
    step(2);
    rst_n = 1'b1;
  endtask

  // Grants must never overlap in any sampled cycle.
  always @(negedge clk) begin
    if (mon_en) check_eq("mutex", {31'd0, u_bus.grant_core1 & u_bus.grant_core2}, 32'd0);
  end

  initial begin
    n_cmp  = 0;
    n_err  = 0;
    mon_en = 1'b0;
    rst_n  = 1'b0;
    u_bus.req_core1 = 1'b0;
    u_bus.req_core2 = 1'b0;
    u_bus.l2_busy   = 1'b0;
    step(2);
    mon_en = 1'b1;

    // reset values while reset is held
    check_eq("rst_g1", {31'd0, u_bus.grant_core1}, 32'd0);
    check_eq("rst_g2", {31'd0, u_bus.grant_core2}, 32'd0);
    check_eq("rst_owner", {30'd0, u_bus.owner_id}, 32'd0);
    check_eq("rst_idle", {31'd0, u_bus.bus_idle}, 32'd1);
    check_eq("rst_preempt", {31'd0, u_bus.preempt}, 32'd0);
    rst_n = 1'b1;

    // single requester: one-cycle latency, TURN then IDLE
    step(2);
    u_bus.req_core1 = 1'b1;
    step();
    check_eq("t1_g1", {31'd0, u_bus.grant_core1}, 32'd1);
    check_eq("t1_owner", {30'd0, u_bus.owner_id}, 32'd1);
    check_eq("t1_idle", {31'd0, u_bus.bus_idle}, 32'd0);
    step(4);
    check_eq("t1_hold", {31'd0, u_bus.grant_core1}, 32'd1);
    u_bus.req_core1 = 1'b0;
    step();
    check_eq("t1_turn_g1", {31'd0, u_bus.grant_core1}, 32'd0);
    check_eq("t1_turn_owner", {30'd0, u_bus.owner_id}, 32'd0);
    check_eq("t1_turn_idle", {31'd0, u_bus.bus_idle}, 32'd0);
    step();
    check_eq("t1_idle_back", {31'd0, u_bus.bus_idle}, 32'd1);

    // simultaneous requests after reset: core1 first, core2 two cycles after drop
    do_reset();
    u_bus.req_core1 = 1'b1;
    u_bus.req_core2 = 1'b1;
    step();
    check_eq("t2_g1", {31'd0, u_bus.grant_core1}, 32'd1);
    check_eq("t2_g2", {31'd0, u_bus.grant_core2}, 32'd0);
    step(2);
    u_bus.req_core1 = 1'b0;
    step();
    check_eq("t2_turn", {30'd0, u_bus.owner_id}, 32'd0);
    step();
    check_eq("t2_gap_g2", {31'd0, u_bus.grant_core2}, 32'd0);
    check_eq("t2_gap_idle", {31'd0, u_bus.bus_idle}, 32'd1);
    step();
    check_eq("t2_g2_on", {31'd0, u_bus.grant_core2}, 32'd1);
    check_eq("t2_owner2", {30'd0, u_bus.owner_id}, 32'd2);
    u_bus.req_core2 = 1'b0;
    step(2);
    check_eq("t2_idle", {31'd0, u_bus.bus_idle}, 32'd1);

    // one-cycle request glitch in IDLE
    u_bus.req_core1 = 1'b1;
    step();
    check_eq("glitch_g1", {31'd0, u_bus.grant_core1}, 32'd1);
    u_bus.req_core1 = 1'b0;
    step();
    check_eq("glitch_turn", {31'd0, u_bus.grant_core1}, 32'd0);
    check_eq("glitch_turn_idle", {31'd0, u_bus.bus_idle}, 32'd0);
    step();
    check_eq("glitch_idle", {31'd0, u_bus.bus_idle}, 32'd1);

    // both held: 16-cycle tenures alternating with a preempt pulse each hand-off
    do_reset();
    u_bus.req_core1 = 1'b1;
    u_bus.req_core2 = 1'b1;
    for (int h = 0; h < 4; h++) begin
      for (int c = 0; c < 16; c++) begin
        step();
        check_eq($sformatf("rr_own_h%0d_c%0d", h, c), {30'd0, u_bus.owner_id},
                 (h % 2 == 0) ? 32'd1 : 32'd2);
        check_eq("rr_no_preempt", {31'd0, u_bus.preempt}, 32'd0);
      end
      step();
      check_eq($sformatf("rr_preempt_h%0d", h), {31'd0, u_bus.preempt}, 32'd1);
      check_eq("rr_turn_owner", {30'd0, u_bus.owner_id}, 32'd0);
      step();
      check_eq("rr_preempt_off", {31'd0, u_bus.preempt}, 32'd0);
      check_eq("rr_idle", {31'd0, u_bus.bus_idle}, 32'd1);
    end
`ifdef BUS_ARB_STATS_EN
    check_eq("stat_preempt", {16'd0, u_bus.preempt_cnt}, 32'd4);
    check_eq("stat_g1", u_bus.grant_cnt1, 32'd2);
    check_eq("stat_g2", u_bus.grant_cnt2, 32'd2);
`endif
    u_bus.req_core1 = 1'b0;
    u_bus.req_core2 = 1'b0;

    // saturated owner, preemption deferred by l2_busy
    do_reset();
    u_bus.req_core1 = 1'b1;
    for (int c = 0; c < 20; c++) begin
      step();
      check_eq("sat_g1", {31'd0, u_bus.grant_core1}, 32'd1);
    end
    u_bus.req_core2 = 1'b1;
    u_bus.l2_busy   = 1'b1;
    for (int c = 0; c < 5; c++) begin
      step();
      check_eq("busy_g1", {31'd0, u_bus.grant_core1}, 32'd1);
      check_eq("busy_preempt", {31'd0, u_bus.preempt}, 32'd0);
    end
    u_bus.l2_busy = 1'b0;
    step();
    check_eq("busy_turn_g1", {31'd0, u_bus.grant_core1}, 32'd0);
    check_eq("busy_turn_preempt", {31'd0, u_bus.preempt}, 32'd1);
    step();
    check_eq("busy_idle", {31'd0, u_bus.bus_idle}, 32'd1);
    step();
    check_eq("busy_g2", {31'd0, u_bus.grant_core2}, 32'd1);
    u_bus.req_core1 = 1'b0;
    u_bus.req_core2 = 1'b0;
    step(2);
    check_eq("busy_done_idle", {31'd0, u_bus.bus_idle}, 32'd1);

    // l2_busy blocks grant in IDLE
    u_bus.l2_busy   = 1'b1;
    u_bus.req_core2 = 1'b1;
    for (int c = 0; c < 3; c++) begin
      step();
      check_eq("blk_g2", {31'd0, u_bus.grant_core2}, 32'd0);
      check_eq("blk_idle", {31'd0, u_bus.bus_idle}, 32'd1);
    end
    u_bus.l2_busy = 1'b0;
    step();
    check_eq("blk_g2_on", {31'd0, u_bus.grant_core2}, 32'd1);

    // asynchronous reset mid-OWN2, then core1 favoured again
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("async_g2", {31'd0, u_bus.grant_core2}, 32'd0);
    check_eq("async_owner", {30'd0, u_bus.owner_id}, 32'd0);
    check_eq("async_idle", {31'd0, u_bus.bus_idle}, 32'd1);
    step();
    rst_n = 1'b1;
    u_bus.req_core1 = 1'b1;
    step();
    check_eq("post_rst_g1", {31'd0, u_bus.grant_core1}, 32'd1);
    check_eq("post_rst_g2", {31'd0, u_bus.grant_core2}, 32'd0);

    mon_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
